video_timing_ctrl: RTL and testbench
====================================

VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, default 96, hsync width (pixels).
REQ-004 Parameter H_BP, default 48, horizontal back porch (pixels).
REQ-005 Parameter V_ACTIVE, default 480, visible lines.
REQ-006 Parameter V_FP, default 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, default 2, vsync width (lines).
REQ-008 Parameter V_BP, default 33, vertical back porch (lines).
REQ-009 Parameter SYNC_POL, default 0, sync asserted level (0 = active-low).
REQ-010 pixel_clk  in  1  sole clock; all logic on its rising edge.
REQ-011 rst  in  1  synchronous, active-high reset.
REQ-012 enable  in  1  request to run frames; level-sensitive.
REQ-013 hsync, vsync  out  1 each  sync pin levels, polarity per SYNC_POL.
REQ-014 active  out  1  high during visible pixels; drives encoder active input.
REQ-015 ctl0  out  2  {vsync,hsync} for the blue-channel encoder ctl input.
REQ-016 hcount, vcount  out  12 each  current pixel/line position.
REQ-017 frame_start  out  1  one-cycle pulse at hcount=0, vcount=0 while running.
REQ-018 busy  out  1  high whenever state is RUN.

Function
REQ-019 The controller SHALL implement two states, IDLE and RUN.
REQ-020 IDLE: hcount=vcount=0, active=0, syncs at inactive level, frame_start=0.
REQ-021 IDLE->RUN when enable=1 is sampled; the next cycle is hcount=0, vcount=0, and frame_start=1.
REQ-022 RUN: hcount increments by 1 and wraps at H_TOTAL-1 (H_TOTAL = sum of H_* parameters); vcount increments on each hcount wrap and wraps at V_TOTAL-1.
REQ-023 The line/frame layout SHALL be active, front porch, sync, back porch, in that order.
REQ-024 active SHALL be 1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-025 hsync SHALL be asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vsync SHALL use the same rule on vcount, asserted for whole lines.
REQ-026 All outputs SHALL be registered and aligned with the hcount/vcount they report, with zero skew between them.
REQ-027 Deasserting enable in RUN SHALL NOT truncate the frame: the controller completes the frame and enters IDLE after hcount=H_TOTAL-1, vcount=V_TOTAL-1.
REQ-028 If enable is re-asserted before frame end, the controller SHALL stay in RUN with no gap; the next frame starts seamlessly.
REQ-029 Counters SHALL be 12-bit unsigned; H_TOTAL and V_TOTAL SHALL be at most 4096.

Reset
REQ-030 While rst=1, the block SHALL enter IDLE with hcount=vcount=0, active=0, frame_start=0, busy=0, hsync=vsync=~SYNC_POL, and ctl0 reflecting those levels.
REQ-031 Reset mid-frame SHALL abort immediately; after rst deasserts, the block SHALL restart only per REQ-021.

Configuration
REQ-032 With VTC_PATTERN_EN defined, the block SHALL add outputs pat_r, pat_g and pat_b (8 bits each), registered and aligned with active, showing 8 equal-width vertical colour bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black.
REQ-033 Pattern values SHALL be 0 outside active pixels.
REQ-034 With VTC_PATTERN_EN undefined, these ports and their logic SHALL be absent.

Structure
REQ-035 Package video_timing_pkg SHALL hold the 640x480@60 timing constants and the four TMDS control-period codes.
REQ-036 Sub-module sync_gen (wrapping counter plus sync/active window compare) SHALL be instantiated once for the horizontal axis and once for the vertical axis.

Verification
Small timing for all scenarios: H=8/2/3/2, V=4/1/2/1, so H_TOTAL=15 and V_TOTAL=8.
REQ-037 rst, then enable=1 -> frame_start=1 on the first RUN cycle, hcount=0, vcount=0, busy=1.
REQ-038 Sweep a full frame -> active on hcount 0-7, vcount 0-3; hsync low on hcount 10-12; vsync low on vcount 5-6; ctl0={vsync,hsync}.
REQ-039 Drop enable at hcount=3, vcount=1 -> frame runs to hcount=14, vcount=7, then IDLE, busy=0, syncs high.
REQ-040 Drop enable, then re-raise it before frame end -> the next frame_start arrives exactly 120 cycles after the previous one.
REQ-041 Assert rst at vcount=2 -> the next cycle is IDLE with all reset values; with enable held, RUN restarts with frame_start.
REQ-042 With VTC_PATTERN_EN defined, sample hcount=0 and hcount=7 -> pattern is white (FF,FF,FF), then black (00,00,00).

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants (640x480@60), TMDS control-period codes and FSM/pattern helpers
// for the video timing controller.
package video_timing_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  // TMDS control-period symbols indexed by {c1,c0}
  localparam logic [9:0] TMDS_CTL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTL_11 = 10'b1010101011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtc_state_e;

  // Colour-bar palette as {r,g,b}
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_ctrl_sync_gen.sv
// One timing axis: wrapping position counter plus next-position active/sync window flags,
// so the parent can register its outputs in the same cycle the counter updates.
module sync_gen #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        adv_i,
  output logic [11:0] count_o,
  output logic        last_o,
  output logic        act_nxt_o,
  output logic        sync_nxt_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [11:0] LAST       = 12'(TOTAL - 1);
  localparam logic [12:0] ACT_END    = 13'(ACTIVE);
  localparam logic [12:0] SYNC_START = 13'(ACTIVE + FP);
  localparam logic [12:0] SYNC_END   = 13'(ACTIVE + FP + SYNC);

  logic [11:0] count_q, count_d;

  assign last_o  = (count_q == LAST);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (!run_i) begin
      count_d = 12'd0;
    end else if (adv_i) begin
      count_d = last_o ? 12'd0 : count_q + 12'd1;
    end else begin
      count_d = count_q;
    end
  end

  assign act_nxt_o  = ({1'b0, count_d} < ACT_END);
  assign sync_nxt_o = ({1'b0, count_d} >= SYNC_START) && ({1'b0, count_d} < SYNC_END);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 12'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Video timing controller: IDLE/RUN frame sequencer with registered, zero-skew sync/active/count
// outputs. Optional colour-bar pattern outputs are built when VTC_PATTERN_EN is defined.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_640,
  parameter int   H_FP     = H_FP_640,
  parameter int   H_SYNC   = H_SYNC_640,
  parameter int   H_BP     = H_BP_640,
  parameter int   V_ACTIVE = V_ACTIVE_480,
  parameter int   V_FP     = V_FP_480,
  parameter int   V_SYNC   = V_SYNC_480,
  parameter int   V_BP     = V_BP_480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [1:0]  ctl0,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        frame_start,
`ifdef VTC_PATTERN_EN
  output logic [7:0]  pat_r,
  output logic [7:0]  pat_g,
  output logic [7:0]  pat_b,
`endif
  output logic        busy
);

  vtc_state_e state_q;
  logic h_last, v_last, h_act_nxt, v_act_nxt, h_sync_nxt, v_sync_nxt;
  logic run_d, act_d, hsync_d, vsync_d, frame_last, h_adv, v_adv;
  logic hsync_q, vsync_q, active_q, frame_start_q, busy_q;
  logic [1:0] ctl0_q;

  assign frame_last = h_last & v_last;
  assign h_adv      = (state_q == ST_RUN);
  assign v_adv      = h_adv & h_last;

  // A frame in flight always runs to its last pixel; enable is only consulted there or in IDLE.
  always_comb begin
    run_d = 1'b0;
    if (rst) begin
      run_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: run_d = enable;
        ST_RUN:  run_d = enable | ~frame_last;
        default: run_d = 1'b0;
      endcase
    end
  end

  assign act_d   = run_d & h_act_nxt & v_act_nxt;
  assign hsync_d = (run_d & h_sync_nxt) ? SYNC_POL : ~SYNC_POL;
  assign vsync_d = (run_d & v_sync_nxt) ? SYNC_POL : ~SYNC_POL;

  sync_gen #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_hgen (
    .clk_i(pixel_clk), .rst_i(rst), .run_i(run_d), .adv_i(h_adv),
    .count_o(hcount), .last_o(h_last), .act_nxt_o(h_act_nxt), .sync_nxt_o(h_sync_nxt)
  );

  sync_gen #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_vgen (
    .clk_i(pixel_clk), .rst_i(rst), .run_i(run_d), .adv_i(v_adv),
    .count_o(vcount), .last_o(v_last), .act_nxt_o(v_act_nxt), .sync_nxt_o(v_sync_nxt)
  );

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      active_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      ctl0_q        <= {~SYNC_POL, ~SYNC_POL};
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= run_d ? ST_RUN : ST_IDLE;
      busy_q        <= run_d;
      active_q      <= act_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      ctl0_q        <= {vsync_d, hsync_d};
      frame_start_q <= run_d & ((state_q == ST_IDLE) | frame_last);
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign ctl0        = ctl0_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

`ifdef VTC_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [11:0] h_nxt_d, bar_d;
  logic [2:0]  bar_idx_d;
  logic [23:0] pat_q;

  // Bar index is derived from the next hcount so the pattern register lines up with active.
  always_comb begin
    h_nxt_d = 12'd0;
    if (state_q == ST_RUN && !h_last) begin
      h_nxt_d = hcount + 12'd1;
    end else begin
      h_nxt_d = 12'd0;
    end
    bar_d     = h_nxt_d / 12'(BAR_W);
    bar_idx_d = (bar_d > 12'd7) ? 3'd7 : bar_d[2:0];
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pat_q <= 24'd0;
    end else begin
      pat_q <= act_d ? bar_colour(bar_idx_d) : 24'd0;
    end
  end

  assign pat_r = pat_q[23:16];
  assign pat_g = pat_q[15:8];
  assign pat_b = pat_q[7:0];
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a 15x8 timing (H=8/2/3/2, V=4/1/2/1, active-low syncs).
module tb_video_timing_ctrl;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        hsync, vsync, active, frame_start, busy;
  logic [1:0]  ctl0;
  logic [11:0] hcount, vcount;
`ifdef VTC_PATTERN_EN
  logic [7:0]  pat_r, pat_g, pat_b;
`endif

  int checks = 0;
  int errors = 0;
  int cur = 0;

  always #5 pixel_clk = ~pixel_clk;

  video_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .enable(enable),
    .hsync(hsync), .vsync(vsync), .active(active), .ctl0(ctl0),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
`ifdef VTC_PATTERN_EN
    .pat_r(pat_r), .pat_g(pat_g), .pat_b(pat_b),
`endif
    .busy(busy)
  );

  typedef struct {
    int          cyc;
    logic [11:0] h;
    logic [11:0] v;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] pat;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  task automatic step();
    @(negedge pixel_clk);
    cur++;
  endtask

  task automatic wait_fs(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      step();
      n++;
      if (frame_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hcount"}, 32'(hcount), 32'd0);
    chk({tag, "_vcount"}, 32'(vcount), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_ctl0"}, 32'(ctl0), 32'd3);
  endtask

  initial begin
    int n;
    bit ok;
    int gap;

    // cycle offset from first RUN cycle: cyc = v*15 + h
    vecs[0]  = '{0,   12'd0,  12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    vecs[1]  = '{1,   12'd1,  12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFF00};
    vecs[2]  = '{4,   12'd4,  12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFF00FF};
    vecs[3]  = '{7,   12'd7,  12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[4]  = '{8,   12'd8,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[5]  = '{9,   12'd9,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[6]  = '{10,  12'd10, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[7]  = '{12,  12'd12, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[8]  = '{13,  12'd13, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[9]  = '{14,  12'd14, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[10] = '{15,  12'd0,  12'd1, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF};
    vecs[11] = '{52,  12'd7,  12'd3, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[12] = '{53,  12'd8,  12'd3, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[13] = '{60,  12'd0,  12'd4, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[14] = '{75,  12'd0,  12'd5, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[15] = '{100, 12'd10, 12'd6, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[16] = '{105, 12'd0,  12'd7, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[17] = '{119, 12'd14, 12'd7, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[18] = '{120, 12'd0,  12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};

    // reset state, then idle with enable low
    rst = 1'b1;
    repeat (3) @(negedge pixel_clk);
    chk_idle("reset");
    rst = 1'b0;
    repeat (3) @(negedge pixel_clk);
    chk_idle("idle_noenable");

    // start: first RUN cycle is the next negedge
    enable = 1'b1;
    cur = -1;
    step();
    for (int i = 0; i < 19; i++) begin
      while (cur < vecs[i].cyc) step();
      chk($sformatf("v%0d_hcount", i), 32'(hcount), 32'(vecs[i].h));
      chk($sformatf("v%0d_vcount", i), 32'(vcount), 32'(vecs[i].v));
      chk($sformatf("v%0d_active", i), 32'(active), 32'(vecs[i].act));
      chk($sformatf("v%0d_hsync", i), 32'(hsync), 32'(vecs[i].hs));
      chk($sformatf("v%0d_vsync", i), 32'(vsync), 32'(vecs[i].vs));
      chk($sformatf("v%0d_ctl0", i), 32'(ctl0), 32'({vecs[i].vs, vecs[i].hs}));
      chk($sformatf("v%0d_fs", i), 32'(frame_start), 32'(vecs[i].fs));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
`ifdef VTC_PATTERN_EN
      chk($sformatf("v%0d_pat", i), {8'd0, pat_r, pat_g, pat_b}, {8'd0, vecs[i].pat});
`endif
    end

    // drop enable at h3 v1 of the second frame; frame must complete
    while (cur < 138) step();
    chk("drop_pos_h", 32'(hcount), 32'd3);
    chk("drop_pos_v", 32'(vcount), 32'd1);
    enable = 1'b0;
    while (cur < 239) step();
    chk("drop_last_h", 32'(hcount), 32'd14);
    chk("drop_last_v", 32'(vcount), 32'd7);
    chk("drop_last_busy", 32'(busy), 32'd1);
    step();
    chk_idle("drop_end");
    repeat (4) step();
    chk_idle("drop_stay");

    // restart latency, then drop/re-raise enable mid-frame: frame period must stay 120
    enable = 1'b1;
    wait_fs(5, n, ok);
    chk("restart_fs_seen", 32'(ok), 32'd1);
    chk("restart_latency", 32'(n), 32'd1);
    repeat (30) step();
    enable = 1'b0;
    repeat (30) step();
    enable = 1'b1;
    wait_fs(200, n, ok);
    gap = 60 + n;
    chk("reraise_fs_seen", 32'(ok), 32'd1);
    chk("reraise_period", 32'(gap), 32'd120);
    chk("reraise_busy", 32'(busy), 32'd1);
    chk("reraise_hcount", 32'(hcount), 32'd0);

    // reset mid-frame at vcount=2 with enable held
    repeat (30) step();
    chk("rst_pos_v", 32'(vcount), 32'd2);
    rst = 1'b1;
    step();
    chk_idle("midrst");
    rst = 1'b0;
    step();
    chk("postrst_fs", 32'(frame_start), 32'd1);
    chk("postrst_busy", 32'(busy), 32'd1);
    chk("postrst_h", 32'(hcount), 32'd0);
    chk("postrst_v", 32'(vcount), 32'd0);
    chk("postrst_active", 32'(active), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
